// File: rtl/fir_sm_buffer.sv
`default_nettype none
// ============================================================================
// fir_sm_buffer : FWFT AXI-Stream output buffer behind the FIR sm_* port,
//                 with fill level, held-frame count and frame-done pulse.
// Revision      : 1.0
// ============================================================================
module fir_sm_buffer #(
  parameter int pDATA_WIDTH  = 32,
  parameter int pDEPTH       = 16,
  parameter int pLEVEL_WIDTH = 5
) (
  input  logic                    axis_clk,
  input  logic                    axis_rst_n,
  input  logic                    clear,
  input  logic                    s_tvalid,
  input  logic [pDATA_WIDTH-1:0]  s_tdata,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    m_tvalid,
  output logic [pDATA_WIDTH-1:0]  m_tdata,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [pLEVEL_WIDTH-1:0] level,
  output logic [pLEVEL_WIDTH-1:0] frames,
  output logic                    frame_done
);

  localparam int                      c_PTR_W = $clog2(pDEPTH);
  localparam logic [pLEVEL_WIDTH-1:0] c_FULL  = pLEVEL_WIDTH'(pDEPTH);

  logic [pDATA_WIDTH:0]    r_mem [pDEPTH];
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [pLEVEL_WIDTH-1:0] r_level;
  logic [pLEVEL_WIDTH-1:0] r_frames;
  logic                    r_frame_done;
  logic                    r_rdy_en;

  logic                    w_wr;
  logic                    w_rd;
  logic                    w_head_last;
  logic                    w_fr_inc;
  logic                    w_fr_dec;

  // Ready depends only on registered state, so a full buffer never passes through.
  assign s_tready    = r_rdy_en & (r_level != c_FULL);
  assign m_tvalid    = (r_level != '0);
  assign m_tdata     = r_mem[r_rd_ptr][pDATA_WIDTH-1:0];
  assign w_head_last = r_mem[r_rd_ptr][pDATA_WIDTH];
  assign m_tlast     = w_head_last;
  assign level       = r_level;
  assign frames      = r_frames;
  assign frame_done  = r_frame_done;

  assign w_wr     = s_tvalid & s_tready;
  assign w_rd     = m_tvalid & m_tready;
  assign w_fr_inc = w_wr & s_tlast;
  assign w_fr_dec = w_rd & w_head_last;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < pDEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_frames     <= '0;
      r_frame_done <= 1'b0;
      r_rdy_en     <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
      if (clear) begin
        // Beats offered or taken in the clear cycle are dropped; contents stay.
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_level      <= '0;
        r_frames     <= '0;
        r_frame_done <= 1'b0;
      end else begin
        if (w_wr) begin
          r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
          r_wr_ptr        <= r_wr_ptr + 1'b1;
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_wr, w_rd})
          2'b10:   r_level <= r_level + 1'b1;
          2'b01:   r_level <= r_level - 1'b1;
          default: r_level <= r_level;
        endcase
        case ({w_fr_inc, w_fr_dec})
          2'b10:   r_frames <= r_frames + 1'b1;
          2'b01:   r_frames <= r_frames - 1'b1;
          default: r_frames <= r_frames;
        endcase
        r_frame_done <= w_fr_dec;
      end
    end
  end

endmodule
`default_nettype wire
